// File: rtl/mem_bus_responder_pkg.sv
// Shared definitions for the memory-side bus responder.
//   state_e          : FSM state encoding (IDLE..DONE), also used by the debug port
//   IO_PAGE_DEFAULT  : addr[15:8] value that selects the game I/O page
//   ERR_RDATA        : read data returned on an aborted (timed-out) I/O access
package mem_bus_responder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RAM_ACC  = 3'd1,
    ST_RAM_WAIT = 3'd2,
    ST_IO_WAIT  = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  localparam logic [7:0]  IO_PAGE_DEFAULT = 8'hFF;
  localparam logic [15:0] ERR_RDATA       = 16'h0000;

endpackage

// File: rtl/mem_bus_responder_if.sv
// Request/response bus between the multicycle control FSM and the memory
// responder.
//   memread/memwrite : request strobes (master -> slave)
//   addr/wdata       : request address and write data (master -> slave)
//   rdata            : read data, valid with ready, held until the next read
//   ready            : one-cycle completion pulse (slave -> master)
//   bus_err          : one-cycle abort flag, only ever high together with ready
//
// Handshake: the master raises exactly one strobe and keeps addr/wdata stable
// until the slave accepts it; the slave accepts only when idle and answers
// each accepted request with exactly one ready pulse. The master must not
// issue a new strobe until it has seen ready.
interface mem_bus_responder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) ();

  logic              memread;
  logic              memwrite;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic              bus_err;

  modport master (
    output memread, memwrite, addr, wdata,
    input  rdata, ready, bus_err
  );

  modport slave (
    input  memread, memwrite, addr, wdata,
    output rdata, ready, bus_err
  );

endinterface

// File: rtl/mem_wait_counter.sv
// Wait-cycle counter shared by the RAM read-latency wait and the I/O ack
// timeout (the two waits are never active together).
//   clk, reset : clock and synchronous active-high reset
//   clr_i      : force the count to zero (held while not waiting)
//   en_i       : advance the count by one
//   last_i     : terminal count value for the current wait
//   tc_o       : count has reached last_i
// The count saturates at last_i so it can never wrap.
module mem_wait_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] last_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tc_o = (cnt_q == last_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder for the control FSM's memread/memwrite strobes.
// One access is accepted per request while idle; addr[15:8]==IO_PAGE routes
// it to the game I/O peripherals, anything else to the synchronous block RAM.
//   clk, reset     : clock, synchronous active-high reset
//   bus            : request/response bus (slave side)
//   ram_*          : block RAM port; ram_rdata valid RAM_LAT cycles after ram_en
//   io_*           : I/O peripheral port; io_req held until io_ack or timeout
//   dbg_state_o    : current FSM state
module mem_bus_responder
  import mem_bus_responder_pkg::*;
#(
  parameter int         DATA_W     = 16,
  parameter int         ADDR_W     = 16,
  parameter logic [7:0] IO_PAGE    = IO_PAGE_DEFAULT,
  parameter int         RAM_LAT    = 1,
  parameter int         IO_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  mem_bus_responder_if.slave bus,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              io_req,
  output logic              io_we,
  output logic [7:0]        io_addr,
  output logic [DATA_W-1:0] io_wdata,
  input  logic [DATA_W-1:0] io_rdata,
  input  logic              io_ack,
  output state_e            dbg_state_o
);

  localparam int MAX_WAIT = (RAM_LAT > IO_TIMEOUT) ? RAM_LAT : IO_TIMEOUT;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);

  // Terminal counts: the counter reads 0 in the first wait cycle.
  localparam logic [CNT_W-1:0] RAM_LAST = CNT_W'(RAM_LAT - 1);
  localparam logic [CNT_W-1:0] IO_LAST  = CNT_W'(IO_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              dir_q, dir_d;        // 1 = write
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              cnt_clr;
  logic              cnt_en;
  logic [CNT_W-1:0]  cnt_last;
  logic              cnt_tc;

  mem_wait_counter #(
    .CNT_W (CNT_W)
  ) u_wait_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .last_i (cnt_last),
    .tc_o   (cnt_tc)
  );

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    io_req    = 1'b0;
    io_we     = 1'b0;
    io_addr   = '0;
    io_wdata  = '0;
    // The counter sits cleared outside the wait states, so every entry
    // into RAM_WAIT/IO_WAIT starts from zero.
    cnt_clr   = 1'b1;
    cnt_en    = 1'b0;
    cnt_last  = IO_LAST;

    unique case (state_q)
      ST_IDLE: begin
        err_d = 1'b0;
        if (bus.memread && bus.memwrite) begin
          // Conflicting strobes: answer with an error, touch nothing.
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (bus.memread || bus.memwrite) begin
          dir_d   = bus.memwrite;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          state_d = (bus.addr[15:8] == IO_PAGE) ? ST_IO_WAIT : ST_RAM_ACC;
        end
      end

      ST_RAM_ACC: begin
        ram_en    = 1'b1;
        ram_we    = dir_q;
        ram_addr  = addr_q;
        ram_wdata = wdata_q;
        state_d   = dir_q ? ST_DONE : ST_RAM_WAIT;
      end

      ST_RAM_WAIT: begin
        cnt_clr  = 1'b0;
        cnt_en   = 1'b1;
        cnt_last = RAM_LAST;
        if (cnt_tc) begin
          rdata_d = ram_rdata;
          state_d = ST_DONE;
        end
      end

      ST_IO_WAIT: begin
        cnt_clr  = 1'b0;
        cnt_en   = 1'b1;
        io_req   = 1'b1;
        io_we    = dir_q;
        io_addr  = addr_q[7:0];
        io_wdata = wdata_q;
        // An ack on the same edge as the timeout still wins.
        if (io_ack) begin
          if (!dir_q) begin
            rdata_d = io_rdata;
          end
          state_d = ST_DONE;
        end else if (cnt_tc) begin
          err_d   = 1'b1;
          rdata_d = DATA_W'(ERR_RDATA);
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      dir_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.rdata   = rdata_q;
  assign bus.ready   = (state_q == ST_DONE);
  assign bus.bus_err = (state_q == ST_DONE) && err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
module tb_mem_bus_responder;
  import mem_bus_responder_pkg::*;

  localparam int DW = 16;
  localparam int AW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic          io_req, io_we, io_ack;
  logic [7:0]    io_addr;
  logic [DW-1:0] io_wdata, io_rdata;
  state_e        dbg_state;

  mem_bus_responder_if #(.DATA_W(DW), .ADDR_W(AW)) bus_if ();

  mem_bus_responder #(
    .DATA_W(DW), .ADDR_W(AW), .IO_PAGE(8'hFF), .RAM_LAT(1), .IO_TIMEOUT(15)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus_if),
    .ram_en      (ram_en),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .io_req      (io_req),
    .io_we       (io_we),
    .io_addr     (io_addr),
    .io_wdata    (io_wdata),
    .io_rdata    (io_rdata),
    .io_ack      (io_ack),
    .dbg_state_o (dbg_state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- RAM model (1-cycle read latency) ----------------
  logic [DW-1:0] ram_mem [256];
  logic [DW-1:0] ref_mem [256];
  int            ram_en_cnt;
  logic          ram_we_seen;
  logic [AW-1:0] ram_addr_seen;
  logic [DW-1:0] ram_wdata_seen;

  initial begin
    ram_rdata = 16'h5A5A;
    forever begin
      @(negedge clk);
      if (ram_en) begin
        ram_en_cnt++;
        ram_we_seen    = ram_we;
        ram_addr_seen  = ram_addr;
        ram_wdata_seen = ram_wdata;
        @(posedge clk);
        #1;
        if (ram_we_seen) begin
          ram_mem[ram_addr_seen[7:0]] = ram_wdata_seen;
        end else begin
          ram_rdata = ram_mem[ram_addr_seen[7:0]];
          @(posedge clk);
          #1 ram_rdata = 16'h5A5A;  // data only valid for one cycle
        end
      end
    end
  end

  // ---------------- I/O model: ack in the io_delay-th io_req cycle ----------------
  int            io_delay = 0;   // 0 = never acknowledge
  logic [DW-1:0] io_val = '0;
  int            io_cyc = 0;
  int            io_req_cnt;
  logic          io_we_seen;
  logic [7:0]    io_addr_seen;
  logic [DW-1:0] io_wdata_seen;

  initial begin
    io_ack   = 1'b0;
    io_rdata = '0;
    forever begin
      @(negedge clk);
      if (io_req) begin
        io_cyc++;
        io_req_cnt++;
        io_we_seen    = io_we;
        io_addr_seen  = io_addr;
        io_wdata_seen = io_wdata;
        if (io_cyc == io_delay) begin
          io_ack   = 1'b1;
          io_rdata = io_val;
        end else begin
          io_ack   = 1'b0;
          io_rdata = 16'h3C3C;
        end
      end else begin
        io_cyc   = 0;
        io_ack   = 1'b0;
        io_rdata = '0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [DW:0]   exp_q[$];      // {bus_err, rdata}
  int            exp_cyc_q[$];  // cycle in which ready must be seen
  logic          mon_en = 1'b0;
  logic [DW-1:0] model_rdata = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (bus_if.ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_ready", 32'(bus_if.ready), 32'd0);
          end else begin
            logic [DW:0] e;
            int          ec;
            e  = exp_q.pop_front();
            ec = exp_cyc_q.pop_front();
            check("resp_err", 32'(bus_if.bus_err), 32'(e[DW]));
            check("resp_rdata", 32'(bus_if.rdata), 32'(e[DW-1:0]));
            check("resp_cycle", cyc, ec);
            model_rdata = e[DW-1:0];
          end
        end else begin
          check("rdata_hold", 32'(bus_if.rdata), 32'(model_rdata));
          check("err_without_ready", 32'(bus_if.bus_err), 32'd0);
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Called just after a rising edge with the DUT idle; the strobe is taken
  // at the next edge and ready is expected lat cycles later.
  task automatic do_access(input logic rd, input logic wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic e_err,
                           input logic [DW-1:0] e_rd, input int lat);
    ram_en_cnt = 0;
    io_req_cnt = 0;
    bus_if.memread  = rd;
    bus_if.memwrite = wr;
    bus_if.addr     = a;
    bus_if.wdata    = d;
    exp_q.push_back({e_err, e_rd});
    exp_cyc_q.push_back(cyc + lat);
    @(posedge clk);
    #1;
    bus_if.memread  = 1'b0;
    bus_if.memwrite = 1'b0;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      check("resp_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  // ---------------- main sequence ----------------
  logic [DW-1:0] last_rd;
  initial begin
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = '0;
      ref_mem[i] = '0;
    end
    reset           = 1'b1;
    bus_if.memread  = 1'b0;
    bus_if.memwrite = 1'b0;
    bus_if.addr     = '0;
    bus_if.wdata    = '0;
    ram_en_cnt      = 0;
    io_req_cnt      = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(bus_if.ready), 32'd0);
    check("rst_bus_err", 32'(bus_if.bus_err), 32'd0);
    check("rst_rdata", 32'(bus_if.rdata), 32'd0);
    check("rst_ram_en", 32'(ram_en), 32'd0);
    check("rst_io_req", 32'(io_req), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    // RAM read
    ram_mem[8'h40] = 16'hBEEF;
    ref_mem[8'h40] = 16'hBEEF;
    do_access(1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 16'hBEEF, 3);
    check("rd_ram_en_cycles", ram_en_cnt, 1);
    check("rd_ram_we", 32'(ram_we_seen), 32'd0);
    check("rd_ram_addr", 32'(ram_addr_seen), 32'h0040);
    check("rd_io_req", io_req_cnt, 0);
    repeat (3) @(posedge clk);
    #1;

    // RAM write, rdata must stay BEEF
    do_access(1'b0, 1'b1, 16'h0010, 16'h1234, 1'b0, 16'hBEEF, 2);
    ref_mem[8'h10] = 16'h1234;
    check("wr_ram_en_cycles", ram_en_cnt, 1);
    check("wr_ram_we", 32'(ram_we_seen), 32'd1);
    check("wr_ram_addr", 32'(ram_addr_seen), 32'h0010);
    check("wr_ram_wdata", 32'(ram_wdata_seen), 32'h1234);

    // read back
    do_access(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h1234, 3);

    // both strobes: error pulse at t+1, nothing touched, rdata kept
    do_access(1'b1, 1'b1, 16'h0020, 16'h0000, 1'b1, 16'h1234, 1);
    check("ill_ram_en", ram_en_cnt, 0);
    check("ill_io_req", io_req_cnt, 0);

    // I/O read, ack in 3rd io_req cycle
    io_delay = 3;
    io_val   = 16'h00A5;
    do_access(1'b1, 1'b0, 16'hFF05, 16'h0000, 1'b0, 16'h00A5, 4);
    check("io_rd_req_cycles", io_req_cnt, 3);
    check("io_rd_addr", 32'(io_addr_seen), 32'h05);
    check("io_rd_we", 32'(io_we_seen), 32'd0);
    check("io_rd_ram_en", ram_en_cnt, 0);

    // I/O write never acknowledged: timeout after 15 cycles
    io_delay = 0;
    do_access(1'b0, 1'b1, 16'hFF02, 16'h0077, 1'b1, 16'h0000, 16);
    check("io_to_req_cycles", io_req_cnt, 15);
    check("io_to_we", 32'(io_we_seen), 32'd1);
    check("io_to_addr", 32'(io_addr_seen), 32'h02);
    check("io_to_wdata", 32'(io_wdata_seen), 32'h0077);

    // ack on the very cycle the timeout expires still succeeds
    io_delay = 15;
    io_val   = 16'h1357;
    do_access(1'b1, 1'b0, 16'hFF10, 16'h0000, 1'b0, 16'h1357, 16);
    check("io_edge_req_cycles", io_req_cnt, 15);

    // random RAM traffic
    last_rd = 16'h1357;
    for (int i = 0; i < 10; i++) begin
      logic [7:0]    a;
      logic [DW-1:0] d;
      a = 8'($urandom_range(0, 255));
      d = 16'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        do_access(1'b0, 1'b1, {8'h00, a}, d, 1'b0, last_rd, 2);
        ref_mem[a] = d;
      end else begin
        do_access(1'b1, 1'b0, {8'h00, a}, 16'h0000, 1'b0, ref_mem[a], 3);
        last_rd = ref_mem[a];
      end
    end

    // reset in 2nd IO_WAIT cycle, with a stray strobe while busy
    io_delay   = 0;
    ram_en_cnt = 0;
    io_req_cnt = 0;
    bus_if.memread = 1'b1;
    bus_if.addr    = 16'hFF07;
    @(posedge clk);
    #1;
    bus_if.memread  = 1'b0;
    bus_if.memwrite = 1'b1;
    bus_if.addr     = 16'h0033;
    bus_if.wdata    = 16'hCAFE;
    @(posedge clk);
    #1;
    bus_if.memwrite = 1'b0;
    reset           = 1'b1;
    @(posedge clk);
    #1;
    reset       = 1'b0;
    model_rdata = '0;
    @(negedge clk);
    check("rst_mid_io_req", 32'(io_req), 32'd0);
    check("rst_mid_state", 32'(dbg_state), 32'(ST_IDLE));
    repeat (10) @(posedge clk);
    #1;
    check("rst_mid_req_cycles", io_req_cnt, 2);
    check("rst_mid_ram_en", ram_en_cnt, 0);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
Memory-side responder for the multicycle control FSM's memread/memwrite strobes. Accepts one access per request and decodes the address. Data-space addresses go to the synchronous block RAM; the top page goes to the memory-mapped game I/O peripherals. Completion is signalled with a one-cycle ready pulse, and returned read data is held stable.

Parameters:
DATA_W, 16, data bus width
ADDR_W, 16, address bus width
IO_PAGE, 8'hFF, value of addr[15:8] that selects I/O space
RAM_LAT, 1, block RAM read latency in cycles (1..3)
IO_TIMEOUT, 15, cycles to wait for io_ack before aborting (1..255)

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
memread  in  1  read request strobe from control FSM
memwrite  in  1  write request strobe from control FSM
addr  in  ADDR_W  request address
wdata  in  DATA_W  write data
rdata  out  DATA_W  read data, valid when ready=1, held until next read completes
ready  out  1  one-cycle completion pulse
bus_err  out  1  one-cycle pulse coincident with ready on an aborted access
ram_en  out  1  RAM access enable
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, RAM_LAT cycles after ram_en
io_req  out  1  I/O request, held until io_ack or timeout
io_we  out  1  I/O write qualifier
io_addr  out  8  I/O register index, addr[7:0]
io_wdata  out  DATA_W  I/O write data
io_rdata  in  DATA_W  I/O read data, valid with io_ack
io_ack  in  1  I/O completion

Behaviour:
- Reset: synchronous, active-high. State goes to IDLE. All outputs go to 0, including rdata. Reset mid-access aborts it: io_req/ram_en drop at that edge, and no ready pulse is produced.
- States: IDLE, RAM_ACC, RAM_WAIT, IO_WAIT, DONE.
- IDLE: at edge t, if exactly one strobe is high:
  - latch addr, wdata and the direction.
  - addr[15:8]==IO_PAGE → IO_WAIT; otherwise → RAM_ACC.
- Both strobes high in IDLE:
  - no RAM or I/O access.
  - → DONE with bus_err=1; rdata unchanged.
- RAM_ACC (one cycle): ram_en=1, ram_addr/ram_wdata from the latches, ram_we=1 for a write.
  - Write → DONE.
  - Read → RAM_WAIT.
- RAM_WAIT:
  - A counter runs RAM_LAT-1 further cycles.
  - On the final cycle, capture ram_rdata into rdata, then → DONE.
  - Read latency: ready is high in cycle t+2+RAM_LAT (t+3 for the default).
  - Write latency: ready is high in cycle t+2.
- IO_WAIT: io_req=1, io_we=direction, io_addr/io_wdata from the latches.
  - io_ack sampled high → capture io_rdata on reads; → DONE.
  - No io_ack after IO_TIMEOUT cycles in IO_WAIT → DONE with bus_err=1 and rdata=0.
  - io_ack on the same edge the timeout expires counts as success.
- DONE (one cycle): ready=1, bus_err as set, then → IDLE.
- A strobe is accepted only in IDLE. Strobes during RAM_ACC/RAM_WAIT/IO_WAIT/DONE are ignored and not queued. The control FSM issues a new strobe only after ready.
- Strobe held high across DONE: it is re-accepted at the first edge back in IDLE, as a new access.
- Counter widths are sized from RAM_LAT/IO_TIMEOUT. The counter clears on every entry to RAM_WAIT/IO_WAIT and never wraps.
- ram_*/io_* data and address outputs return to 0 outside their active states.

Decomposition:
- Shared package holds:
  - state encoding constants for IDLE..DONE.
  - IO_PAGE default.
  - the error read value (16'h0000).
- One sub-module: mem_wait_counter. Cycle counter with clear, enable and terminal-count compare. Instanced once and shared by RAM_WAIT and IO_WAIT, since they are mutually exclusive.

Test Plan:
- RAM read: memread=1, addr=16'h0040, RAM model returns 16'hBEEF one cycle after ram_en → ram_en high exactly one cycle, ready pulse at t+3, rdata=16'hBEEF held afterwards, bus_err=0.
- RAM write: memwrite=1, addr=16'h0010, wdata=16'h1234 → one cycle with ram_en=1, ram_we=1, ram_addr=16'h0010, ram_wdata=16'h1234; ready at t+2; rdata unchanged.
- I/O read with delay: memread=1, addr=16'hFF05, io_ack after 3 cycles with io_rdata=16'h00A5 → io_req high 3 cycles with io_addr=8'h05, then ready with rdata=16'h00A5.
- I/O timeout: memwrite=1, addr=16'hFF02, io_ack never asserted → io_req high exactly 15 cycles, then ready=1 and bus_err=1 for one cycle, rdata=0.
- Illegal request: memread=memwrite=1 → no ram_en/io_req; ready and bus_err pulse at t+1.
- Reset mid-access: reset asserted in the 2nd IO_WAIT cycle → io_req=0 the next cycle, no ready pulse. A strobe arriving during the busy cycles before reset is never serviced.
